// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a valid/ready write port feeds a circular FIFO
// that drains into a fixed-rate serial shifter.
module uart_tx_buffered #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] baud_cnt, baud_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          push, pop, baud_done;

  assign wr_ready  = fifo_count < CW'(FIFO_DEPTH);
  assign push      = wr_valid && wr_ready;
  assign baud_done = baud_cnt == BW'(CLKS_PER_BIT - 1);
  assign busy      = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
    end
  end

  // Data bits shift right so the bit on the line is always shift[0]; tx is
  // loaded one edge early so every bit period is exactly CLKS_PER_BIT cycles.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_done ? '0 : baud_cnt + BW'(1);
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    tx_nxt    = tx;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        baud_nxt = '0;
        if (fifo_count != '0) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (baud_done) begin
          bit_nxt   = '0;
          tx_nxt    = shift[0];
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          if (bit_idx == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            bit_nxt   = bit_idx + 3'd1;
            shift_nxt = {1'b0, shift[7:1]};
            tx_nxt    = shift[1];
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          if (fifo_count != '0) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            tx_nxt    = 1'b0;
            state_nxt = START;
          end else begin
            tx_nxt    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at CLKS_PER_BIT=4, FIFO_DEPTH=4; tx is
// compared cycle by cycle against hand-built 8N1 frames.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

  localparam int CPB = 4;

  logic       clk;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; the byte is presented across the following posedge.
  task automatic push_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Checks tx at the current negedge and each following one, frame cycles first..39.
  task automatic expect_frame(input logic [7:0] b, input int first, input bit inj, input logic [7:0] inj_b);
    int   k;
    logic e;
    for (int i = first; i < 10 * CPB; i++) begin
      k = i / CPB;
      if (k == 0)      e = 1'b0;
      else if (k == 9) e = 1'b1;
      else             e = b[k-1];
      check($sformatf("frame_%02h_bit%0d_cyc%0d", b, k, i), tx, e);
      if (inj && i == 10 * CPB - 1) begin
        wr_valid = 1'b1;
        wr_data  = inj_b;
      end
      @(negedge clk);
      if (inj) wr_valid = 1'b0;
    end
  endtask

  int   exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
  int   exp_rdy [6] = '{1, 1, 1, 1, 0, 0};
  logic seen_low;

  initial begin
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_ready", wr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);

    // Single byte: one-cycle FIFO latency before the start bit.
    push_byte(8'hA5);
    check("single_count_queued", fifo_count, 1);
    check("single_busy", busy, 1);
    check("single_tx_idle", tx, 1);
    @(negedge clk);
    check("single_count_popped", fifo_count, 0);
    expect_frame(8'hA5, 0, 1'b0, 8'h00);
    check("single_busy_end", busy, 0);
    check("single_tx_end", tx, 1);

    // Back-to-back frames with no idle gap.
    push_byte(8'h00);
    push_byte(8'hFF);
    check("b2b_count", fifo_count, 1);
    expect_frame(8'h00, 0, 1'b0, 8'h00);
    expect_frame(8'hFF, 0, 1'b0, 8'h00);
    check("b2b_busy_end", busy, 0);
    check("b2b_tx_end", tx, 1);

    // Push on the stop-expiry edge that also pops.
    push_byte(8'h3C);
    push_byte(8'hC3);
    expect_frame(8'h3C, 0, 1'b1, 8'h5A);
    check("pushpop_count", fifo_count, 1);
    expect_frame(8'hC3, 0, 1'b0, 8'h00);
    expect_frame(8'h5A, 0, 1'b0, 8'h00);
    check("pushpop_busy_end", busy, 0);

    // Fill: six consecutive writes, sixth dropped.
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i + 1);
      @(negedge clk);
      check($sformatf("full_count_%0d", i), fifo_count, exp_cnt[i]);
      check($sformatf("full_ready_%0d", i), wr_ready, exp_rdy[i]);
    end
    wr_valid = 1'b0;
    expect_frame(8'h01, 4, 1'b0, 8'h00);
    for (int i = 2; i <= 5; i++) expect_frame(8'(i), 0, 1'b0, 8'h00);
    check("full_busy_end", busy, 0);
    check("full_count_end", fifo_count, 0);
    seen_low = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) seen_low = 1'b1;
    end
    check("full_no_sixth_frame", seen_low, 0);

    // Reset during data bit 3 of 0x96 (bit 3 = 0), with a second byte queued.
    push_byte(8'h96);
    push_byte(8'h69);
    repeat (17) @(negedge clk);
    check("midrst_pre_tx", tx, 0);
    check("midrst_pre_count", fifo_count, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_count", fifo_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", wr_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    seen_low = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) seen_low = 1'b1;
    end
    check("midrst_tx_stays_high", seen_low, 0);
    check("midrst_busy_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter that sits directly downstream of the CPU core's memory-mapped output port. It accepts bytes from the core through a valid/ready write interface and holds them in a small FIFO. It serializes them onto a single 8N1 line at a fixed clocks-per-bit rate. Buffering lets the core issue several stores back-to-back without stalling on each frame.

## Interface
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); must be >= 2
- FIFO_DEPTH, 16, byte entries in the FIFO; power of two, >= 2
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- wr_valid  input  1  core presents a byte to transmit
- wr_data  input  8  byte to transmit
- wr_ready  output  1  FIFO can accept a byte this cycle
- tx  output  1  serial line, idle high, registered
- busy  output  1  FIFO non-empty or frame in progress
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being shifted

## Operation
- Write handshake: a byte is accepted on a rising edge where wr_valid && wr_ready. wr_ready = (fifo_count < FIFO_DEPTH) and depends only on registered count, never on same-cycle pop. A write with wr_ready=0 is dropped and has no side effect.
- FIFO: circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH. fifo_count is tracked separately.
  - Push only: count +1.
  - Pop only: count -1.
  - Push and pop on the same edge: count unchanged, both pointers advance.
- Transmit FSM states:
  - IDLE: tx=1. If count>0, pop the head into the shift register, drive tx=0, clear the baud counter, and go to START.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0 and tx=shift[0].
  - DATA: each bit holds for CLKS_PER_BIT cycles, LSB first. After bit 7 expires, drive tx=1 and go to STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. On expiry: if count>0, pop, drive tx=0, and go to START directly with no idle gap. Otherwise go to IDLE.
- Baud counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1. It expires when it equals CLKS_PER_BIT-1 and then returns to 0.
- busy = (state != IDLE) || (count != 0), decoded from registers.

## Timing
- Reset values (applied asynchronously while reset=1):
  - tx=1, state=IDLE, fifo_count=0, busy=0, wr_ready=1
  - pointers=0, baud counter=0, bit index=0
- Reset mid-frame: tx returns high immediately and the queued bytes are discarded. After release, no transmission occurs until a new write.
- Latency: a byte written at edge N into an empty FIFO with the FSM in IDLE pops at edge N+1, so tx falls after edge N+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles. A back-to-back frame's start bit begins on the edge on which the previous stop bit expires.
- Single isolated frame: busy goes low after edge N+1+10*CLKS_PER_BIT.
- Every bit period is exactly CLKS_PER_BIT cycles with no jitter.
- Full boundary: when count reaches FIFO_DEPTH, wr_ready drops in the following cycle. A pop at that edge raises wr_ready one cycle later.
- Empty boundary: a pop never occurs with count=0. A write into an empty FIFO is never bypassed directly to the shifter; it always passes through the FIFO (one-cycle latency).

## Test plan
- Reset: hold reset 3 cycles, then release -> tx=1, wr_ready=1, busy=0, fifo_count=0. Assert reset for 1 cycle at an arbitrary time -> the same values appear without waiting for a clock edge.
- Single byte (CLKS_PER_BIT=4): write 0xA5 at edge N -> tx=0 for cycles N+1..N+4, then data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1 for 4 cycles. busy falls after edge N+41.
- Back-to-back: write 0x00 and 0xFF on consecutive cycles -> 80 contiguous frame cycles. The second start bit directly follows the first stop bit, and there is no extra idle-high cycle.
- Full (FIFO_DEPTH=4, CLKS_PER_BIT=4): wr_valid high for 6 consecutive cycles with bytes 0x01..0x06 starting at edge N -> 0x01 pops at N+1, fifo_count reaches 4 after edge N+4, wr_ready=0 at N+5, and 0x06 is dropped. Exactly 5 frames (0x01..0x05) are emitted.
- Simultaneous push/pop: with fifo_count=1, write a byte on the edge where a stop bit expires -> fifo_count stays 1, and the popped byte is the older one.
- Reset mid-frame: two bytes queued, assert reset during data bit 3 -> tx=1 immediately and fifo_count=0. After release, tx stays high for 100 cycles.
